// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key expander.
//   SBOX      : 256-entry forward S-box, index 0 is the most significant byte
//   RCON      : round constants, RCON[r] is the MSB byte of Rcon word r (1..10)
//   state_t   : expander control states
//   rot_word  : cyclic left rotate of a 32-bit word by one byte
//   sbox      : single-byte S-box lookup
//   sub_word  : S-box applied to each byte of a word
//   rcon_word : Rcon word for round r, zero outside 1..10
package aes_pkg;

    localparam int KEY_BITS = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Padded to 16 entries so any 4-bit round number indexes in range.
    localparam logic [0:15][7:0] RCON = 128'h0001020408102040801b360000000000;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        return {RCON[r], 24'h000000};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
//   word_in  : input word, byte 0 in [31:24]
//   word_out : S-box substituted word, same byte order
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign word_out[8*i +: 8] = sbox(word_in[8*i +: 8]);
    end

endmodule

// File: rtl/aes_inv_key_expander.sv
// AES-128 key expander that emits the round keys in decryption order
// (round 10 down to round 0). The forward schedule is run in place for ten
// cycles, then each accepted key is unwound one round with the inverse step,
// so only one 128-bit working key is ever stored.
//   clk, resetn : clock, asynchronous active-low reset
//   start       : begin a schedule (sampled only when idle)
//   cipher_key  : round-0 key, w0 = [127:96]
//   key_ready   : downstream accepts round_key this cycle
//   key_valid   : round_key / round_idx valid
//   round_key   : current round key (registered)
//   round_idx   : round number of round_key, 10 down to 0
//   busy        : schedule in progress
//   done        : one-cycle pulse after round 0 is accepted
module aes_inv_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] cipher_key,
    input  logic                 key_ready,
    output logic                 key_valid,
    output logic [KEY_WIDTH-1:0] round_key,
    output logic [3:0]           round_idx,
    output logic                 busy,
    output logic                 done
);

    if (KEY_WIDTH != KEY_BITS) begin : g_bad_key_width
        $error("aes_inv_key_expander: only KEY_WIDTH=128 is supported");
    end

    // The counter value F never occurs during a schedule; parking it there
    // for one idle cycle produces the done pulse without an extra flop.
    localparam logic [3:0] DONE_MARK = 4'hF;

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [KEY_WIDTH-1:0] key_q, key_nxt;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p1, p2, p3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] i0;
    logic [31:0] sw_in, sw_out, rc_w;
    logic [3:0]  rc_idx;
    logic        emitting;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign emitting = (state == ST_EMIT);

    // Previous-round words 1..3 fall out of XORing neighbouring current words.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // One S-box bank serves both directions: forward rounds substitute the
    // current w3, inverse rounds substitute the recovered previous w3.
    assign sw_in  = emitting ? rot_word(p3) : rot_word(w3);
    assign rc_idx = emitting ? cnt : cnt + 4'd1;
    assign rc_w   = rcon_word(rc_idx);

    aes_sub_word u_sub_word (
        .word_in  (sw_in),
        .word_out (sw_out)
    );

    assign f0 = w0 ^ sw_out ^ rc_w;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign i0 = w0 ^ sw_out ^ rc_w;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            key_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            key_q <= key_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        key_nxt   = key_q;
        case (state)
            ST_IDLE: begin
                cnt_nxt = 4'd0;
                if (start) begin
                    key_nxt   = cipher_key;
                    state_nxt = ST_FWD;
                end
            end
            ST_FWD: begin
                key_nxt = {f0, f1, f2, f3};
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd9) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (key_ready) begin
                    if (cnt == 4'd0) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = DONE_MARK;
                    end else begin
                        key_nxt = {i0, p1, p2, p3};
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign key_valid = emitting;
    assign busy      = (state == ST_FWD) || emitting;
    assign done      = (state == ST_IDLE) && (cnt == DONE_MARK);
    assign round_idx = emitting ? cnt : 4'd0;
    assign round_key = key_q;

endmodule

// File: tb/tb_aes_inv_key_expander.sv
`timescale 1ns/1ps
module tb_aes_inv_key_expander;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [127:0] cipher_key;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] KAT_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KAT_R9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_inv_key_expander #(.KEY_WIDTH(128)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .cipher_key (cipher_key),
        .key_ready  (key_ready),
        .key_valid  (key_valid),
        .round_key  (round_key),
        .round_idx  (round_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: FIPS-197 key expansion ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_m[a] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 128'(key_valid), 128'(0));
        check({tag, "_key"},   round_key,       128'(0));
        check({tag, "_idx"},   128'(round_idx), 128'(0));
        check({tag, "_busy"},  128'(busy),      128'(0));
        check({tag, "_done"},  128'(done),      128'(0));
    endtask

    // Called #1 after an edge; returns #1 after the first EMIT edge.
    task automatic begin_schedule(input logic [127:0] key, input bit glitch);
        model_expand(key);
        cipher_key = key;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check("fwd_busy",  128'(busy),      128'(1));
            check("fwd_valid", 128'(key_valid), 128'(0));
            key_ready = 1'($urandom_range(0, 1));
            if (glitch) begin
                cipher_key = rand_key();
                start = (i == 4);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: 5-cycle stall at stall_at.
    task automatic emit_keys(input int mode, input int stall_at, input int rst_at,
                             input bit kat, output bit aborted);
        int r, cyc, stall;
        bit rdy;
        r = 10; cyc = 0; stall = 0; aborted = 1'b0;
        while (r >= 0 && cyc < 200) begin
            check("emit_valid", 128'(key_valid), 128'(1));
            check("emit_idx",   128'(round_idx), 128'(r[3:0]));
            check("emit_key",   round_key,       exp_rk[r]);
            check("emit_done",  128'(done),      128'(0));
            if (kat && r == 9) check("kat_r9", round_key, KAT_R9);
            if (r == rst_at) begin
                resetn = 1'b0;
                #1;
                check_all_zero("rst_emit");
                aborted = 1'b1;
                return;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (r == stall_at && stall < 5) begin rdy = 1'b0; stall++; end
                    else rdy = 1'b1;
                end
            endcase
            key_ready = rdy;
            @(posedge clk); #1;
            cyc++;
            if (rdy) r--;
        end
        if (r >= 0) begin
            check("emit_timeout_round", 128'(r), 128'(-1));
        end else begin
            check("done_pulse", 128'(done),      128'(1));
            check("valid_drop", 128'(key_valid), 128'(0));
            check("busy_drop",  128'(busy),      128'(0));
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("done_clear", 128'(done), 128'(0));
        check("idle_busy",  128'(busy), 128'(0));
    endtask

    initial begin
        bit ab;
        resetn = 1'b0; start = 1'b0; key_ready = 1'b0; cipher_key = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Known-answer schedule, ready tied high.
        begin_schedule(KAT_KEY, 1'b0);
        check("kat_r10", round_key, KAT_R10);
        emit_keys(0, -1, -1, 1'b1, ab);
        idle_cycle();

        // Backpressure: 5-cycle stall at round 7.
        begin_schedule(KAT_KEY, 1'b0);
        emit_keys(2, 7, -1, 1'b1, ab);
        idle_cycle();

        // start and cipher_key disturbed during FWD must not matter.
        begin_schedule(rand_key(), 1'b1);
        emit_keys(0, -1, -1, 1'b0, ab);

        // start in the done cycle is honoured.
        begin_schedule(rand_key(), 1'b0);
        emit_keys(1, -1, -1, 1'b0, ab);
        idle_cycle();

        // Reset at round 4, then start on the first edge with resetn high.
        begin_schedule(rand_key(), 1'b0);
        emit_keys(0, -1, 4, 1'b0, ab);
        check("rst_aborted", 128'(ab), 128'(1));
        @(posedge clk); #1;
        check_all_zero("rst_hold");
        resetn = 1'b1;
        begin_schedule(FIPS_KEY, 1'b0);
        check("fips_r10", round_key, FIPS_R10);
        emit_keys(1, -1, -1, 1'b0, ab);
        idle_cycle();

        // Reset mid-FWD: afterwards the block stays idle until a new start.
        cipher_key = rand_key();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_all_zero("rst_fwd");
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_busy",  128'(busy),      128'(0));
            check("post_rst_valid", 128'(key_valid), 128'(0));
        end

        // Random keys with random backpressure.
        for (int n = 0; n < 1000; n++) begin
            begin_schedule(rand_key(), ($urandom_range(0, 7) == 0));
            emit_keys(1, -1, -1, 1'b0, ab);
            if ($urandom_range(0, 1) != 0) idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
